pulpemu_clk_div_multi: RTL and testbench
========================================

PULPEMU_CLK_DIV_MULTI -- requirements
Module: pulpemu_clk_div_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of divisor and per-channel counter.
REQ-003 SHALL have parameter DEFAULT_DIV, default 256: divisor loaded into every channel at reset.
REQ-004 SHALL have port clk_i  input  1  single clock for all logic.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en_i  input  NUM_CH  per-channel run enable.
REQ-007 SHALL have port cfg_valid_i  input  1  divisor-update request valid.
REQ-008 SHALL have port cfg_ready_o  output  1  divisor-update request can be accepted.
REQ-009 SHALL have port cfg_ch_i  input  max(1,$clog2(NUM_CH))  target channel of the update.
REQ-010 SHALL have port cfg_div_i  input  CNT_WIDTH  new divisor.
REQ-011 SHALL have port cfg_err_o  output  1  one-cycle pulse on an accepted request with cfg_ch_i >= NUM_CH.
REQ-012 SHALL have port clk_o  output  NUM_CH  registered divided clock per channel.
REQ-013 SHALL have port tick_o  output  NUM_CH  registered one-cycle pulse in the first high cycle of each clk_o period.

Function
REQ-014 Per channel, effective divisor D SHALL be max(div_reg, 2); values 0 and 1 clamp to 2; DEFAULT_DIV clamps the same way.
REQ-015 Running channel: counter cnt SHALL step 0..D-1 and wrap to 0; period exactly D clk_i cycles.
REQ-016 clk_o SHALL be high while cnt < ceil(D/2), low otherwise (high ceil(D/2), low floor(D/2) cycles); registered, aligned with cnt.
REQ-017 tick_o SHALL be 1 exactly in cycles where running and cnt == 0, else 0.
REQ-018 Per-channel states: IDLE (cnt=0, clk_o=0) and RUN.
REQ-019 IDLE -> RUN: en_i sampled high at edge t SHALL give cnt=0, clk_o=1, tick_o=1 after edge t (one-cycle latency).
REQ-020 RUN -> IDLE: only at wrap edge (cnt == D-1) with en_i sampled low at that edge; clk_o stays 0, so no runt pulse; en_i deasserted then reasserted before wrap SHALL have no effect.
REQ-021 Handshake: transfer occurs when cfg_valid_i & cfg_ready_o at a clk_i edge; cfg_ready_o SHALL be combinational = not pending[cfg_ch_i] (1 for out-of-range cfg_ch_i).
REQ-022 Accepted in-range request SHALL write cfg_div_i into that channel's pending register and set pending.
REQ-023 Pending divisor SHALL be applied (div_reg updated, pending cleared) at the channel's next wrap edge when RUN, or at the next edge when IDLE.
REQ-024 Request accepted in the same cycle as a wrap of its channel SHALL be applied at the following wrap, never mid-period.
REQ-025 Accepted out-of-range request SHALL be discarded and pulse cfg_err_o for one cycle after the edge; no channel state changes.
REQ-026 Channels SHALL be fully independent; an update to channel k SHALL not disturb counters or outputs of any other channel.
REQ-027 Pending apply and IDLE->RUN in the same edge: new divisor SHALL govern the first period.

Reset
REQ-028 rst_i high at an edge SHALL force every channel to IDLE: cnt=0, clk_o=0, tick_o=0, div_reg=DEFAULT_DIV, pending=0; cfg_err_o=0; cfg_ready_o=1.
REQ-029 Reset mid-period or with pending updates SHALL discard them; rst_i SHALL dominate en_i and cfg_valid_i in the same cycle.

Verification
REQ-030 Reset, en_i=01, default 256 -> ch0 clk_o high 128 / low 128 cycles, tick_o every 256 cycles, first tick one cycle after en_i; ch1 stays 0.
REQ-031 Odd divisor: write D=5 to ch0 while IDLE, enable -> clk_o pattern 1,1,1,0,0 repeating; D=0 and D=1 -> period 2, 1,0.
REQ-032 Update mid-period: ch0 running D=8, write D=4 at cnt=3 -> current 8-cycle period completes intact, then periods of 4; cfg_ready_o low from acceptance until that wrap, second write stalls.
REQ-033 Disable mid-high: drop en_i at cnt=1 with D=10 -> output finishes 5 high / 5 low, then stays 0; re-enable 3 cycles later -> restart with tick_o.
REQ-034 cfg_ch_i=3 with NUM_CH=2 -> cfg_err_o single pulse, both channels unchanged; simultaneous wrap+write case per REQ-024.
REQ-035 rst_i asserted with pending update and channel at cnt=5 -> next cycle all outputs 0, cfg_ready_o=1, divisor back to DEFAULT_DIV.

Source files
------------

// File: rtl/pulpemu_clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free enable and wrap-aligned divisor updates.
// Each channel produces a registered divided clock plus a tick in the first high cycle of every period.
module pulpemu_clk_div_multi #(
    parameter int  NUM_CH      = 2,
    parameter int  CNT_WIDTH   = 16,
    parameter int  DEFAULT_DIV = 256,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_CH-1:0]    en_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [CH_W-1:0]      cfg_ch_i,
    input  logic [CNT_WIDTH-1:0] cfg_div_i,
    output logic                 cfg_err_o,
    output logic [NUM_CH-1:0]    clk_o,
    output logic [NUM_CH-1:0]    tick_o
);

    localparam logic [CH_W:0]        NUM_CH_W = (CH_W+1)'(NUM_CH);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH:0]   ONE_X    = (CNT_WIDTH+1)'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [NUM_CH-1:0] pending;
    logic              ch_in_range;
    logic              accept;

    // A channel with an update already queued refuses another until it is applied.
    always_comb begin
        ch_in_range = ({1'b0, cfg_ch_i} < NUM_CH_W);
        cfg_ready_o = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_ch_i == CH_W'(k)) begin
                cfg_ready_o = ~pending[k];
            end
        end
        accept = cfg_valid_i & cfg_ready_o;
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= accept & ~ch_in_range;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t               state;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] div_reg;
        logic [CNT_WIDTH-1:0] pend_div;
        logic                 pend_q;
        logic                 clk_q;
        logic                 tick_q;
        logic [CNT_WIDTH-1:0] d_cur;
        logic [CNT_WIDTH:0]   half;
        logic [CNT_WIDTH:0]   cnt_inc;
        logic                 wrap;
        logic                 apply;
        logic                 wr_hit;

        always_comb begin
            d_cur   = (div_reg < TWO) ? TWO : div_reg;
            half    = ({1'b0, d_cur} + ONE_X) >> 1;
            cnt_inc = {1'b0, cnt} + ONE_X;
            wrap    = (state == ST_RUN) && (cnt == d_cur - ONE);
            // Updates only land between periods, so a running channel never sees a mid-period change.
            apply   = pend_q && ((state == ST_IDLE) || wrap);
            wr_hit  = accept && (cfg_ch_i == CH_W'(g));
        end

        // NOTE: divisor and pending storage are reset too, so a restart never inherits a stale update.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
                div_reg  <= CNT_WIDTH'(DEFAULT_DIV);
                pend_div <= '0;
                pend_q   <= 1'b0;
            end else begin
                if (apply) begin
                    div_reg <= pend_div;
                    pend_q  <= 1'b0;
                end else if (wr_hit) begin
                    pend_div <= cfg_div_i;
                    pend_q   <= 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        cnt    <= '0;
                        clk_q  <= en_i[g];
                        tick_q <= en_i[g];
                        if (en_i[g]) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (wrap) begin
                            // Stopping only at the wrap keeps the low phase complete: no runt pulse.
                            cnt    <= '0;
                            clk_q  <= en_i[g];
                            tick_q <= en_i[g];
                            if (!en_i[g]) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt    <= cnt + ONE;
                            clk_q  <= (cnt_inc < half);
                            tick_q <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign pending[g] = pend_q;
        assign clk_o[g]   = clk_q;
        assign tick_o[g]  = tick_q;
    end

endmodule

// File: tb/tb_pulpemu_clk_div_multi.sv
// Self-checking bench for pulpemu_clk_div_multi: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a period-based reference model.
module tb_pulpemu_clk_div_multi;

    localparam int NUM_CH      = 3;
    localparam int CNT_WIDTH   = 16;
    localparam int DEFAULT_DIV = 256;
    localparam int CH_W        = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NUM_CH-1:0]    en_i;
    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic [CH_W-1:0]      cfg_ch_i;
    logic [CNT_WIDTH-1:0] cfg_div_i;
    logic                 cfg_err_o;
    logic [NUM_CH-1:0]    clk_o;
    logic [NUM_CH-1:0]    tick_o;

    pulpemu_clk_div_multi #(
        .NUM_CH     (NUM_CH),
        .CNT_WIDTH  (CNT_WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_err_o  (cfg_err_o),
        .clk_o      (clk_o),
        .tick_o     (tick_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    bit rdy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each running channel is described by the cycle its current period
    // started and that period's length; outputs follow from the elapsed time.
    int m_cyc;
    bit m_run  [NUM_CH];
    int m_start[NUM_CH];
    int m_len  [NUM_CH];
    int m_div  [NUM_CH];
    bit m_pend [NUM_CH];
    int m_pval [NUM_CH];
    bit m_err;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_run[k]  = 1'b0;
            m_start[k] = 0;
            m_len[k]  = 2;
            m_div[k]  = DEFAULT_DIV;
            m_pend[k] = 1'b0;
            m_pval[k] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic bit m_ready(input int ch);
        if (ch >= NUM_CH) return 1'b1;
        return !m_pend[ch];
    endfunction

    function automatic logic [NUM_CH-1:0] m_clk();
        logic [NUM_CH-1:0] r;
        for (int k = 0; k < NUM_CH; k++) begin
            r[k] = m_run[k] && ((m_cyc - m_start[k]) < (m_len[k] + 1) / 2);
        end
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] m_tick();
        logic [NUM_CH-1:0] r;
        for (int k = 0; k < NUM_CH; k++) begin
            r[k] = m_run[k] && (m_cyc == m_start[k]);
        end
        return r;
    endfunction

    task automatic model_edge(input bit rst, input logic [NUM_CH-1:0] en, input bit valid,
                              input int ch, input int div);
        bit acc;
        bit ends;
        if (rst) begin
            model_reset();
            m_cyc++;
            return;
        end
        acc   = valid && m_ready(ch);
        m_err = acc && (ch >= NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
            ends = m_run[k] && ((m_cyc - m_start[k]) == m_len[k] - 1);
            if (m_pend[k] && (!m_run[k] || ends)) begin
                m_div[k]  = m_pval[k];
                m_pend[k] = 1'b0;
            end else if (acc && ch == k) begin
                m_pend[k] = 1'b1;
                m_pval[k] = div;
            end
            if ((!m_run[k] || ends) && en[k]) begin
                m_run[k]   = 1'b1;
                m_start[k] = m_cyc + 1;
                m_len[k]   = (m_div[k] < 2) ? 2 : m_div[k];
            end else if (ends) begin
                m_run[k] = 1'b0;
            end
        end
        m_cyc++;
    endtask

    // One clock cycle: drive inputs, check ready before the edge, check outputs after it.
    task automatic step(input bit rst, input logic [NUM_CH-1:0] en, input bit valid,
                        input int ch, input int div);
        rst_i       = rst;
        en_i        = en;
        cfg_valid_i = valid;
        cfg_ch_i    = ch[CH_W-1:0];
        cfg_div_i   = div[CNT_WIDTH-1:0];
        #1;
        rdy_seen = cfg_ready_o;
        check("cfg_ready_o vs model", cfg_ready_o, m_ready(ch));
        @(posedge clk_i);
        model_edge(rst, en, valid, ch, div);
        #1;
        check("clk_o vs model", clk_o, m_clk());
        check("tick_o vs model", tick_o, m_tick());
        check("cfg_err_o vs model", cfg_err_o, m_err);
    endtask

    task automatic run(input int n, input logic [NUM_CH-1:0] en);
        for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 0);
    endtask

    // Reset, then load a divisor into idle ch0 and let it apply.
    task automatic load_ch0(input int div);
        step(1'b1, '0, 1'b0, 0, 0);
        step(1'b0, '0, 1'b1, 0, div);
        step(1'b0, '0, 1'b0, 0, 0);
    endtask

    typedef struct {
        bit                rst;
        logic [NUM_CH-1:0] en;
        bit                valid;
        int                ch;
        int                div;
        bit                ready;
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] tick;
        bit                err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p5[10]  = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        int p2[4]   = '{1, 0, 1, 0};
        int p32[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        int p33[13] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        int p34[8]  = '{1, 1, 0, 0, 1, 0, 1, 0};
        int highs, ticks, ch1_highs, first_low;

        //           rst   en      vld   ch div  rdy   clk     tick    err
        vecs[0]  = '{1'b1, 3'b000, 1'b0, 0, 0, 1'b1, 3'b000, 3'b000, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 1'b1, 0, 0, 1'b1, 3'b000, 3'b000, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 1'b0, 0, 0, 1'b0, 3'b000, 3'b000, 1'b0};
        vecs[3]  = '{1'b0, 3'b001, 1'b0, 0, 0, 1'b1, 3'b001, 3'b001, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 1'b0, 0, 0, 1'b1, 3'b000, 3'b000, 1'b0};
        vecs[5]  = '{1'b0, 3'b001, 1'b0, 0, 0, 1'b1, 3'b001, 3'b001, 1'b0};
        vecs[6]  = '{1'b0, 3'b001, 1'b1, 3, 9, 1'b1, 3'b000, 3'b000, 1'b1};
        vecs[7]  = '{1'b0, 3'b001, 1'b0, 0, 0, 1'b1, 3'b001, 3'b001, 1'b0};
        vecs[8]  = '{1'b0, 3'b000, 1'b0, 0, 0, 1'b1, 3'b000, 3'b000, 1'b0};
        vecs[9]  = '{1'b0, 3'b000, 1'b0, 0, 0, 1'b1, 3'b000, 3'b000, 1'b0};
        vecs[10] = '{1'b0, 3'b000, 1'b0, 0, 0, 1'b1, 3'b000, 3'b000, 1'b0};
        vecs[11] = '{1'b0, 3'b010, 1'b1, 1, 3, 1'b1, 3'b010, 3'b010, 1'b0};
        vecs[12] = '{1'b0, 3'b010, 1'b0, 1, 0, 1'b0, 3'b010, 3'b000, 1'b0};
        vecs[13] = '{1'b1, 3'b011, 1'b1, 1, 5, 1'b0, 3'b000, 3'b000, 1'b0};

        rst_i = 1'b1; en_i = '0; cfg_valid_i = 1'b0; cfg_ch_i = '0; cfg_div_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        m_cyc = 0;
        model_reset();

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].ch, vecs[i].div);
            check($sformatf("vec%0d ready", i), rdy_seen, vecs[i].ready);
            check($sformatf("vec%0d clk_o", i), clk_o, vecs[i].clk);
            check($sformatf("vec%0d tick_o", i), tick_o, vecs[i].tick);
            check($sformatf("vec%0d cfg_err_o", i), cfg_err_o, vecs[i].err);
        end

        // Default divisor: 128 high / 128 low, ticks every 256 cycles, ch1 silent.
        step(1'b1, '0, 1'b0, 0, 0);
        highs = 0; ticks = 0; ch1_highs = 0; first_low = -1;
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 3'b001, 1'b0, 0, 0);
            if (i == 0) check("default first tick", tick_o[0], 1);
            if (i == 256) check("default second tick", tick_o[0], 1);
            if (i < 256 && clk_o[0]) highs++;
            if (first_low < 0 && !clk_o[0]) first_low = i;
            if (tick_o[0]) ticks++;
            if (clk_o[1]) ch1_highs++;
        end
        check("default high cycles", highs, 128);
        check("default first low cycle", first_low, 128);
        check("default tick count", ticks, 2);
        check("default ch1 idle", ch1_highs, 0);

        // Odd divisor and the clamped divisors 0 and 1.
        load_ch0(5);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 3'b001, 1'b0, 0, 0);
            check($sformatf("div5 clk_o[%0d]", i), clk_o[0], p5[i]);
        end
        for (int d = 0; d < 2; d++) begin
            load_ch0(d);
            for (int i = 0; i < 4; i++) begin
                step(1'b0, 3'b001, 1'b0, 0, 0);
                check($sformatf("div%0d clk_o[%0d]", d, i), clk_o[0], p2[i]);
            end
        end

        // Mid-period update: D=8 running, write D=4 at cnt=3, second write stalls.
        load_ch0(8);
        run(4, 3'b001);
        step(1'b0, 3'b001, 1'b1, 0, 4);
        check("update accepted ready", rdy_seen, 1);
        check("update seq[0]", clk_o[0], p32[0]);
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 3'b001, 1'b1, 0, 6);
            check($sformatf("update stall ready %0d", i), rdy_seen, 0);
            check($sformatf("update seq[%0d]", i), clk_o[0], p32[i]);
        end
        for (int i = 5; i < 12; i++) begin
            step(1'b0, 3'b001, 1'b0, 0, 0);
            check($sformatf("update seq[%0d]", i), clk_o[0], p32[i]);
        end

        // Disable at cnt=1 with D=10, then re-enable three idle cycles later.
        load_ch0(10);
        for (int i = 0; i < 13; i++) begin
            step(1'b0, (i < 2) ? 3'b001 : 3'b000, 1'b0, 0, 0);
            check($sformatf("disable seq[%0d]", i), clk_o[0], p33[i]);
        end
        step(1'b0, 3'b001, 1'b0, 0, 0);
        check("re-enable tick", tick_o[0], 1);
        check("re-enable clk", clk_o[0], 1);

        // Out-of-range channel while both channels run.
        step(1'b1, '0, 1'b0, 0, 0);
        run(3, 3'b011);
        step(1'b0, 3'b011, 1'b1, 3, 9);
        check("bad channel err pulse", cfg_err_o, 1);
        step(1'b0, 3'b011, 1'b0, 0, 0);
        check("bad channel err clears", cfg_err_o, 0);
        check("bad channel ch0 ready", rdy_seen, 1);

        // Write accepted on the wrap edge applies one period later.
        load_ch0(4);
        run(4, 3'b001);
        step(1'b0, 3'b001, 1'b1, 0, 2);
        check("wrap write ready", rdy_seen, 1);
        check("wrap write seq[0]", clk_o[0], p34[0]);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 3'b001, 1'b0, 0, 0);
            check($sformatf("wrap write seq[%0d]", i), clk_o[0], p34[i]);
        end

        // Reset with pending update at cnt=5 restores the default divisor.
        load_ch0(8);
        run(3, 3'b001);
        step(1'b0, 3'b001, 1'b1, 0, 3);
        run(2, 3'b001);
        step(1'b1, 3'b001, 1'b1, 0, 7);
        check("reset clk_o", clk_o, 0);
        check("reset tick_o", tick_o, 0);
        check("reset cfg_err_o", cfg_err_o, 0);
        step(1'b0, 3'b000, 1'b0, 0, 0);
        check("reset ready", rdy_seen, 1);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 3'b001, 1'b0, 0, 0);
            if (clk_o[0]) highs++;
        end
        check("reset default high cycles", highs, 128);

        // Randomized traffic against the model.
        step(1'b1, '0, 1'b0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_CH-1:0] en;
            en = ($urandom_range(0, 9) < 8) ? NUM_CH'(3'b111 & $urandom) | 3'b001 : NUM_CH'($urandom);
            step(($urandom_range(0, 499) == 0), en, ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
